i2s_tx_mix: RTL

//  Output stage downstream of the mixer. Pops one mixed 24-bit sample per output channel once per frame.

---
 rtl/i2s_tx_mix.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/i2s_tx_mix.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// i2s_tx_mix
// Output stage behind the mixer. Once per frame it requests one 24-bit sample
// per output channel. It holds the sample that arrives as pending, then copies
// it into a shadow register at the frame boundary. The shadow pair is sent as
// a stereo I2S stream: 64fs BCK, 24-bit data left-justified one BCK after the
// LRCK edge inside a 32-bit slot.
//
// Ports
//   clk            system clock (49.152 MHz -> 1024 clk per 48 kHz frame)
//   rst_n          asynchronous reset, active-low
//   en_i           stream enable; low holds the frame counter at 0 and mutes
//   pop_o          one-cycle sample request per channel at frame start
//   ack_i          per-channel sample strobe from the mixer
//   data_i         sample for the channel(s) flagged in ack_i
//   bck_o          I2S bit clock
//   lrck_o         I2S word clock (0 = left, 1 = right)
//   sdata_o        I2S serial data, MSB first
//   underrun_o     one-cycle pulse: channel had no sample at frame load
//   overrun_o      one-cycle pulse: a pending sample was replaced
//   underrun_cnt_o saturating total of underrun events
// ----------------------------------------------------------------------------
module i2s_tx_mix #(
    parameter int NUM_CH_OUT       = 2,
    parameter int CLK_PER_BCK_LOG2 = 4,
    parameter int UNDERRUN_W       = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en_i,
    output logic [NUM_CH_OUT-1:0]   pop_o,
    input  logic [NUM_CH_OUT-1:0]   ack_i,
    input  logic [23:0]             data_i,
    output logic                    bck_o,
    output logic                    lrck_o,
    output logic                    sdata_o,
    output logic [NUM_CH_OUT-1:0]   underrun_o,
    output logic [NUM_CH_OUT-1:0]   overrun_o,
    output logic [UNDERRUN_W-1:0]   underrun_cnt_o
);

    // Frame = 2 channels x 32 bit slots x 2^CLK_PER_BCK_LOG2 clk per bit.
    localparam int CNT_W = CLK_PER_BCK_LOG2 + 6;

    logic [CNT_W-1:0]       cnt_reg;
    logic [23:0]            pending_reg [NUM_CH_OUT];
    logic [23:0]            shadow_reg  [NUM_CH_OUT];
    logic [NUM_CH_OUT-1:0]  pending_valid_reg;
    logic [NUM_CH_OUT-1:0]  underrun_reg;
    logic [NUM_CH_OUT-1:0]  overrun_reg;
    logic [UNDERRUN_W-1:0]  underrun_cnt_reg;
    logic                   bck_reg;
    logic                   lrck_reg;
    logic                   sdata_reg;

    logic                   frame_start;
    logic                   frame_load;
    logic [NUM_CH_OUT-1:0]  capture;
    logic [NUM_CH_OUT-1:0]  underrun_evt;
    logic [NUM_CH_OUT-1:0]  overrun_evt;

    assign frame_start = en_i && (cnt_reg == '0);
    assign frame_load  = en_i && (cnt_reg == '1);

    // Gated with rst_n so the request stays low while reset is held even
    // though the counter sits at 0 with the stream enabled.
    assign pop_o = {NUM_CH_OUT{frame_start && rst_n}};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH_OUT; gi++) begin : g_ch
            assign capture[gi]      = en_i && ack_i[gi];
            assign overrun_evt[gi]  = capture[gi] && pending_valid_reg[gi];
            assign underrun_evt[gi] = frame_load && !pending_valid_reg[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Frame counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (!en_i) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel capture and frame load. A capture in the load cycle
    // lands in pending after shadow has taken the old pending value,
    // because both read the pre-edge register contents.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < NUM_CH_OUT; ch++) begin
                pending_reg[ch] <= '0;
                shadow_reg[ch]  <= '0;
            end
            pending_valid_reg <= '0;
            underrun_reg      <= '0;
            overrun_reg       <= '0;
        end else begin
            for (int ch = 0; ch < NUM_CH_OUT; ch++) begin
                if (!en_i) begin
                    pending_valid_reg[ch] <= 1'b0;
                end else begin
                    if (frame_load) begin
                        shadow_reg[ch]        <= pending_valid_reg[ch] ? pending_reg[ch] : 24'd0;
                        pending_valid_reg[ch] <= 1'b0;
                    end
                    if (capture[ch]) begin
                        pending_reg[ch]       <= data_i;
                        pending_valid_reg[ch] <= 1'b1;
                    end
                end
            end
            underrun_reg <= underrun_evt;
            overrun_reg  <= overrun_evt;
        end
    end

    // ------------------------------------------------------------------
    // Saturating underrun total; both channels may add in the same cycle.
    // ------------------------------------------------------------------
    logic [1:0]            underrun_add;
    logic [UNDERRUN_W:0]   underrun_sum;

    assign underrun_add = {1'b0, underrun_evt[0]} + {1'b0, underrun_evt[1]};
    assign underrun_sum = {1'b0, underrun_cnt_reg} + {{(UNDERRUN_W-1){1'b0}}, underrun_add};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_cnt_reg <= '0;
        end else if (underrun_sum[UNDERRUN_W]) begin
            underrun_cnt_reg <= '1;
        end else begin
            underrun_cnt_reg <= underrun_sum[UNDERRUN_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Serialiser. Bit b of the slot maps to shadow bit 24-b for b=1..24;
    // the rest of the slot is padding.
    // ------------------------------------------------------------------
    logic [4:0]  slot_bit;
    logic        ch_sel;
    logic [4:0]  data_idx;
    logic [23:0] cur_word;
    logic        sdata_next;

    assign slot_bit = cnt_reg[CNT_W-2:CLK_PER_BCK_LOG2];
    assign ch_sel   = cnt_reg[CNT_W-1];
    assign data_idx = 5'd24 - slot_bit;
    assign cur_word = shadow_reg[ch_sel];

    always_comb begin
        sdata_next = 1'b0;
        if ((slot_bit >= 5'd1) && (slot_bit <= 5'd24)) begin
            sdata_next = cur_word[data_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bck_reg   <= 1'b0;
            lrck_reg  <= 1'b0;
            sdata_reg <= 1'b0;
        end else if (!en_i) begin
            bck_reg   <= 1'b0;
            lrck_reg  <= 1'b0;
            sdata_reg <= 1'b0;
        end else begin
            bck_reg   <= cnt_reg[CLK_PER_BCK_LOG2-1];
            lrck_reg  <= cnt_reg[CNT_W-1];
            sdata_reg <= sdata_next;
        end
    end

    assign bck_o          = bck_reg;
    assign lrck_o         = lrck_reg;
    assign sdata_o        = sdata_reg;
    assign underrun_o     = underrun_reg;
    assign overrun_o      = overrun_reg;
    assign underrun_cnt_o = underrun_cnt_reg;

endmodule
